// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SIZE_W = 2;
  localparam int CNT_W  = 4;
  localparam int LANES  = DATA_W / 8;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane enables for an access of the given size at the given offset.
  function automatic logic [LANES-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                                 input logic [1:0] offset);
    logic [LANES-1:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << offset;
      SIZE_HALF: m = 4'b0011 << offset;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_load_align.sv
// Moves the addressed lane of a storage word down to bit 0 and extends it.
module load_align
  import mem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [SIZE_W-1:0] size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // Shift the addressed byte lane to the bottom, then zero- or sign-extend.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SIZE_BYTE: data = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with configurable wait states.
// state   | meaning
// IDLE    | ready for a request
// WAIT    | counting wait states down to zero
// RESP    | response held until the initiator takes it
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               we_q, uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;
  logic [SIZE_W-1:0]  size_q;
  logic               err_q;
  logic               accept, resp_entry;

  logic               acc_we, acc_uns, acc_err;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata, rd_word, aligned, wr_data;
  logic [SIZE_W-1:0]  acc_size;
  logic [IDX_W-1:0]   idx;
  logic [LANES-1:0]   lanes;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    case (state)
      ST_IDLE: if (req_valid) begin
        accept   = 1'b1;
        state_nx = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (cnt == '0) state_nx = ST_RESP;
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    resp_entry = (state != ST_RESP) && (state_nx == ST_RESP);
  end

  // With zero wait states the access happens on the accept edge itself,
  // before the latches hold the request, so take the fields straight from the port.
  always_comb begin
    acc_we    = (state == ST_IDLE) ? req_we       : we_q;
    acc_addr  = (state == ST_IDLE) ? req_addr     : addr_q;
    acc_wdata = (state == ST_IDLE) ? req_wdata    : wdata_q;
    acc_size  = (state == ST_IDLE) ? req_size     : size_q;
    acc_uns   = (state == ST_IDLE) ? req_unsigned : uns_q;
    acc_err   = (acc_size == 2'd3)
             || (acc_size == SIZE_HALF && acc_addr[0])
             || (acc_size == SIZE_WORD && acc_addr[1:0] != 2'b00)
             || (acc_addr[ADDR_W-1:2] >= 30'(DEPTH_WORDS));
    idx       = acc_addr[IDX_W+1:2];
    rd_word   = mem[idx];
    lanes     = lane_mask(acc_size, acc_addr[1:0]);
    case (acc_size)
      SIZE_BYTE: wr_data = {4{acc_wdata[7:0]}};
      SIZE_HALF: wr_data = {2{acc_wdata[15:0]}};
      default:   wr_data = acc_wdata;
    endcase
  end

  load_align u_align (
    .word        (rd_word),
    .offset      (acc_addr[1:0]),
    .size        (acc_size),
    .unsigned_ld (acc_uns),
    .data        (aligned)
  );

  // Storage: one write per legal store, on entry to RESP; never reset.
  always_ff @(posedge clk) begin
    if (reset && resp_entry && acc_we && !acc_err) begin
      for (int k = 0; k < LANES; k++) begin
        if (lanes[k]) mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // State register, request latches, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        cnt     <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (resp_entry) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? '0 : aligned;
      end else if (state == ST_RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder plus back-pressure and reset sequences.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, hold_rd;
    logic        er, hold_er;
    int          lat;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; rsp_ready = 1'b0;

    vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h13,  32'h0000007F, 2'd0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h7FADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h11,  32'h0,        2'd0, 1'b0, 32'hFFFFFFBE, 1'b0});
    vecs.push_back('{1'b0, 32'h11,  32'h0,        2'd0, 1'b1, 32'h000000BE, 1'b0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'h00007FAD, 1'b0});
    vecs.push_back('{1'b1, 32'h11,  32'h0000FFFF, 2'd1, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h7FADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h13,  32'h0,        2'd1, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h12,  32'h00008001, 2'd1, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h8001BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0,   32'h11111111, 2'd2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h100, 32'h22222222, 2'd2, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0,   32'h0,        2'd2, 1'b0, 32'h11111111, 1'b0});
    vecs.push_back('{1'b1, 32'h14,  32'h00000000, 2'd2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h15,  32'hFFFFFFA5, 2'd0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        2'd2, 1'b0, 32'h0000A500, 1'b0});
    vecs.push_back('{1'b0, 32'h15,  32'h0,        2'd0, 1'b0, 32'hFFFFFFA5, 1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        2'd1, 1'b1, 32'h0000A500, 1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        2'd1, 1'b0, 32'hFFFFA500, 1'b0});
    vecs.push_back('{1'b1, 32'h20,  32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'hFC,  32'h0BADC0DE, 2'd2, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFC,  32'h0,        2'd2, 1'b0, 32'h0BADC0DE, 1'b0});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAITS + 1));
      chk($sformatf("vec%0d_ready_after_hs", i), 32'(req_ready), 32'd1);
    end

    // back-pressure: response held for 5 cycles while another request waits
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 32'h0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'(WAITS + 1));
    hold_rd = rsp_rdata;
    hold_er = rsp_err;
    chk("bp_rdata", hold_rd, 32'h8001BEEF);
    chk("bp_err", 32'(hold_er), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), rsp_rdata, hold_rd);
      chk($sformatf("bp_err_c%0d", c), 32'(rsp_err), 32'(hold_er));
      chk($sformatf("bp_req_ready_c%0d", c), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_req_ready_after_hs", 32'(req_ready), 32'd1);
    chk("bp_valid_after_hs", 32'(rsp_valid), 32'd0);

    // reset while a store waits
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_in_wait", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort_no_rsp_c%0d", c), 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("abort_word_unchanged", rd, 32'hCAFEF00D);
    chk("abort_reload_err", 32'(er), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states between request accept and response; range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-011 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  access was misaligned, out of range or illegal size.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on any edge where req_valid and req_ready are both 1.
REQ-019 On accept, the responder SHALL latch we, addr, wdata, size and unsigned, then transition:
- to WAIT when WAIT_CYCLES > 0;
- to RESP when WAIT_CYCLES = 0.
REQ-020 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and move to RESP on the cycle the counter equals 0.
REQ-021 Accept-to-rsp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL hold stable until the rsp_valid&&rsp_ready edge.
REQ-023 That rsp_valid&&rsp_ready edge SHALL return the FSM to IDLE.
REQ-024 A new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-025 Error conditions, each of which SHALL set rsp_err=1:
- size 3;
- half access with addr[0]=1;
- word access with addr[1:0]≠0;
- word index addr[31:2] ≥ DEPTH_WORDS.
REQ-026 An errored store SHALL NOT modify storage.
REQ-027 An errored load SHALL return rsp_rdata=0.
REQ-028 A legal store SHALL update only the addressed byte lanes, selected by addr[1:0] and size, exactly once, on the cycle of entry to RESP.
REQ-029 A legal load SHALL read the word on entry to RESP, shift the addressed lane down by 8*addr[1:0], and extend it to 32 bits per req_unsigned.
REQ-030 Byte lanes SHALL be little-endian: byte k is located at bits 8k+7:8k.
REQ-031 The address wraps only through the index check: addresses at or beyond DEPTH_WORDS*4 SHALL error and SHALL NOT alias.
REQ-032 Storage contents after power-up SHALL be undefined; the bench SHALL NOT rely on them.

Reset
REQ-033 While reset=0 at an edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and latched request fields SHALL clear.
REQ-034 Output values during and after reset SHALL be: req_ready=1 (after reset), rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-035 Reset asserted in WAIT or RESP SHALL abort the transaction with no response and no storage write.
REQ-036 Storage SHALL NOT be cleared by reset.

Structure
REQ-037 The access-size encoding (BYTE/HALF/WORD) and the FSM state enum SHALL live in the shared types package.
REQ-038 The width constants SHALL live in the same package.
REQ-039 The lane shift and extension logic SHALL be a combinational sub-module, load_align, with inputs word, offset, size and unsigned and output data.
REQ-040 The storage array SHALL be inferred inside mem_responder.

Verification
REQ-041 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises exactly WAIT_CYCLES+1 cycles after each accept.
REQ-042 After REQ-041:
- store byte 0x7F @0x13, then load word @0x10 -> 0x7FADBEEF;
- load byte signed @0x11 -> 0xFFFFFFBE;
- load byte unsigned @0x11 -> 0x000000BE.
REQ-043 Load half signed @0x12 after REQ-042 -> 0x00007FAD.
REQ-044 Store half @0x11 -> rsp_err=1 and word @0x10 unchanged.
REQ-045 Load @DEPTH_WORDS*4 -> rsp_err=1 and rsp_rdata=0.
REQ-046 Response back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-047 Reset mid-operation: assert reset=0 while in WAIT during a store of 0x12345678 @0x20 -> no rsp_valid, word @0x20 unchanged, req_ready=1 after reset is released.
